// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared addr/data bus. Grants one full
// transaction (address phase + one data phase) with a data-phase watchdog.
module bus_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  // master 0
  input  logic                  m0_addr_valid,
  input  logic                  m0_write_enable,
  input  logic                  m0_write_data_valid,
  input  logic                  m0_read_data_ready,
  input  logic [DATA_WIDTH-1:0] m0_common,
  output logic                  m0_addr_ready,
  output logic                  m0_write_data_ready,
  output logic                  m0_read_data_valid,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  // master 1
  input  logic                  m1_addr_valid,
  input  logic                  m1_write_enable,
  input  logic                  m1_write_data_valid,
  input  logic                  m1_read_data_ready,
  input  logic [DATA_WIDTH-1:0] m1_common,
  output logic                  m1_addr_ready,
  output logic                  m1_write_data_ready,
  output logic                  m1_read_data_valid,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  // bus side
  output logic                  s_addr_valid,
  output logic                  s_write_enable,
  output logic                  s_write_data_valid,
  output logic                  s_read_data_ready,
  output logic [DATA_WIDTH-1:0] s_common,
  input  logic                  s_addr_ready,
  input  logic                  s_write_data_ready,
  input  logic                  s_read_data_valid,
  input  logic [DATA_WIDTH-1:0] s_read_data,
  // status
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_ABORT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_g, r_last, r_we, r_timeout;
  logic            w_g_nxt, w_last_nxt, w_we_nxt, w_timeout_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  // Request signals of the currently granted master
  logic                  w_av, w_we_in, w_wdv, w_rdr;
  logic [DATA_WIDTH-1:0] w_common;
  // Responses destined for the granted master
  logic                  w_ar, w_wdr, w_rdv;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_av     = r_g ? m1_addr_valid       : m0_addr_valid;
  assign w_we_in  = r_g ? m1_write_enable     : m0_write_enable;
  assign w_wdv    = r_g ? m1_write_data_valid : m0_write_data_valid;
  assign w_rdr    = r_g ? m1_read_data_ready  : m0_read_data_ready;
  assign w_common = r_g ? m1_common           : m0_common;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt        = r_state;
    w_g_nxt            = r_g;
    w_last_nxt         = r_last;
    w_we_nxt           = r_we;
    w_cnt_nxt          = r_cnt;
    w_timeout_nxt      = r_timeout;
    s_addr_valid       = 1'b0;
    s_write_enable     = 1'b0;
    s_write_data_valid = 1'b0;
    s_read_data_ready  = 1'b0;
    s_common           = '0;
    w_ar               = 1'b0;
    w_wdr              = 1'b0;
    w_rdv              = 1'b0;
    w_rd               = '0;

    unique case (r_state)
      S_IDLE: begin
        if (m0_addr_valid | m1_addr_valid) begin
          // On a tie the master that did not own the bus last wins
          w_g_nxt     = (m0_addr_valid & m1_addr_valid) ? ~r_last : m1_addr_valid;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        s_addr_valid   = w_av;
        s_write_enable = w_we_in;
        s_common       = w_common;
        w_ar           = s_addr_ready;
        if (w_av & s_addr_ready) begin
          w_we_nxt    = w_we_in;
          w_cnt_nxt   = '0;
          w_state_nxt = w_we_in ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        s_write_data_valid = w_wdv;
        s_common           = w_common;
        w_wdr              = s_write_data_ready;
        if (w_wdv & s_write_data_ready) begin
          w_last_nxt  = r_g;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_ABORT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RDATA: begin
        s_read_data_ready = w_rdr;
        w_rdv             = s_read_data_valid;
        w_rd              = s_read_data;
        if (w_rdr & s_read_data_valid) begin
          w_last_nxt  = r_g;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_ABORT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ABORT: begin
        // Bus is released; the arbiter itself completes the master's data phase
        if (r_we) begin
          w_wdr = w_wdv;
          if (w_wdv) begin
            w_last_nxt  = r_g;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_rdv = 1'b1;
          w_rd  = ERR_DATA;
          if (w_rdr) begin
            w_last_nxt  = r_g;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_g       <= 1'b0;
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_g       <= w_g_nxt;
      r_last    <= w_last_nxt;
      r_we      <= w_we_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign m0_addr_ready       = ~r_g & w_ar;
  assign m0_write_data_ready = ~r_g & w_wdr;
  assign m0_read_data_valid  = ~r_g & w_rdv;
  assign m0_read_data        = r_g ? '0 : w_rd;
  assign m1_addr_ready       =  r_g & w_ar;
  assign m1_write_data_ready =  r_g & w_wdr;
  assign m1_read_data_valid  =  r_g & w_rdv;
  assign m1_read_data        = r_g ? w_rd : '0;

  assign o_grant   = (r_state == S_IDLE) ? 2'b00 : {r_g, ~r_g};
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table of single transactions driven through
// a scoreboard, plus hand sequences for reset-in-RDATA and round-robin ties.
module tb_bus_arbiter;

  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    m_av, m_we, m_wdv, m_rdr;
  logic [DW-1:0] m_common [2];
  logic [1:0]    m_ar, m_wdr, m_rdv;
  logic [DW-1:0] m_rd [2];
  logic          s_av, s_we, s_wdv, s_rdr;
  logic [DW-1:0] s_common;
  logic          s_ar, s_wdr, s_rdv;
  logic [DW-1:0] s_rd;
  logic [1:0]    o_grant;
  logic          o_timeout;

  bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk                 (clk),
    .reset               (reset),
    .m0_addr_valid       (m_av[0]),
    .m0_write_enable     (m_we[0]),
    .m0_write_data_valid (m_wdv[0]),
    .m0_read_data_ready  (m_rdr[0]),
    .m0_common           (m_common[0]),
    .m0_addr_ready       (m_ar[0]),
    .m0_write_data_ready (m_wdr[0]),
    .m0_read_data_valid  (m_rdv[0]),
    .m0_read_data        (m_rd[0]),
    .m1_addr_valid       (m_av[1]),
    .m1_write_enable     (m_we[1]),
    .m1_write_data_valid (m_wdv[1]),
    .m1_read_data_ready  (m_rdr[1]),
    .m1_common           (m_common[1]),
    .m1_addr_ready       (m_ar[1]),
    .m1_write_data_ready (m_wdr[1]),
    .m1_read_data_valid  (m_rdv[1]),
    .m1_read_data        (m_rd[1]),
    .s_addr_valid        (s_av),
    .s_write_enable      (s_we),
    .s_write_data_valid  (s_wdv),
    .s_read_data_ready   (s_rdr),
    .s_common            (s_common),
    .s_addr_ready        (s_ar),
    .s_write_data_ready  (s_wdr),
    .s_read_data_valid   (s_rdv),
    .s_read_data         (s_rd),
    .o_grant             (o_grant),
    .o_timeout           (o_timeout)
  );

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          responds;
    bit          exp_to;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb [$];
  int   gq [$];
  txn_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m_av = '0; m_we = '0; m_wdv = '0; m_rdr = '0;
    m_common[0] = '0; m_common[1] = '0;
    s_ar = 1'b0; s_wdr = 1'b0; s_rdv = 1'b0; s_rd = '0;
  endtask

  function automatic logic any_out();
    return |{m_ar, m_wdr, m_rdv, m_rd[0], m_rd[1], s_av, s_we, s_wdv, s_rdr,
             s_common, o_grant, o_timeout};
  endfunction

  task automatic do_txn(input txn_t t);
    int         k = int'(t.m);
    int         o = 1 - int'(t.m);
    logic [1:0] eg = t.m ? 2'b10 : 2'b01;
    bit         done = 1'b0;
    bit         fire;
    exp_t       e;
    // IDLE: request seen
    @(negedge clk);
    idle_inputs();
    m_av[k] = 1'b1; m_we[k] = t.we; m_common[k] = t.addr;
    e.data = t.we ? t.wdata : (t.responds ? t.rdata : ERR);
    e.cyc  = t.responds ? t.lat : TO;
    sb.push_back(e);
    #1;
    check("idle_grant", o_grant, 2'b00);
    check("idle_s_av", s_av, 1'b0);
    // ADDR
    @(negedge clk);
    s_ar = 1'b1;
    #1;
    check("addr_grant", o_grant, eg);
    check("addr_s_av", s_av, 1'b1);
    check("addr_s_common", s_common, t.addr);
    check("addr_s_we", s_we, t.we);
    check("addr_m_ar", {m_ar[o], m_ar[k]}, 2'b01);
    // Data phase (and ABORT if the target stays silent)
    for (int c = 0; c < TO + 4 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        m_av[k] = 1'b0; s_ar = 1'b0; m_common[k] = t.wdata;
        m_wdv[k] = t.we; m_rdr[k] = !t.we;
      end
      fire  = t.responds && (c == t.lat);
      s_wdr = fire && t.we;
      s_rdv = fire && !t.we;
      s_rd  = fire ? t.rdata : (32'h5A00_0000 | 32'(c));
      #1;
      check("data_grant", o_grant, eg);
      check("other_quiet", {m_ar[o], m_wdr[o], m_rdv[o], |m_rd[o]}, 4'b0);
      if (t.we ? m_wdr[k] : m_rdv[k]) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", c, e.cyc);
          if (!t.we) check("rdata", m_rd[k], e.data);
          else if (t.responds) check("wdata", s_common, e.data);
        end
        if (c == TO) check("abort_bus_quiet", {s_av, s_wdv, s_rdr, |s_common}, 4'b0);
        done = 1'b1;
      end else if (t.we) begin
        check("wdata_drive", {s_wdv, s_common}, {1'b1, t.wdata});
      end else begin
        check("rdata_drive", s_rdr, 1'b1);
      end
    end
    if (!done) check("txn_no_response", 1'b0, 1'b1);
    check("o_timeout", o_timeout, t.exp_to);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rem [2];
    int cyc;
    bit prev_hs;

    //        m     we    addr          wdata          rdata          lat resp exp_to
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 2, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0,         0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0030, 32'h5A5A_A5A5, 32'h0,         3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 7, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'h0,         0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0050, 32'h0,         32'h0000_7777, 1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_0054, 32'h1111_2222, 32'h0,         0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h0000_0058, 32'h3333_4444, 32'h0,         7, 1'b1, 1'b1};

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outputs", any_out(), 1'b0);

    foreach (tbl[i]) do_txn(tbl[i]);

    // Reset while m0 waits in RDATA
    @(negedge clk);
    idle_inputs();
    m_av[0] = 1'b1; m_common[0] = 32'h60;
    @(negedge clk);
    s_ar = 1'b1;
    @(negedge clk);
    m_av[0] = 1'b0; s_ar = 1'b0; m_rdr[0] = 1'b1;
    @(negedge clk);
    #1;
    check("rdata_pre_reset_grant", o_grant, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    m_av = 2'b11; m_rdr = 2'b11; s_ar = 1'b1; s_rdv = 1'b1;
    m_common[0] = 32'h100; m_common[1] = 32'h200;
    #1;
    check("post_reset_outputs", any_out(), 1'b0);

    // Round-robin: both masters issue 3 back-to-back reads from the tie
    rem[0] = 3; rem[1] = 3;
    for (int j = 0; j < 3; j++) begin
      gq.push_back(0);
      gq.push_back(1);
    end
    cyc = 0;
    prev_hs = 1'b0;
    while ((rem[0] + rem[1]) > 0 && cyc < 40) begin
      @(negedge clk);
      s_rd = 32'hA000_0000 + 32'(cyc);
      m_av[0] = rem[0] > 0;
      m_av[1] = rem[1] > 0;
      #1;
      if (prev_hs) check("rr_gap_idle", o_grant, 2'b00);
      prev_hs = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (m_rdv[j]) begin
          if (gq.size() == 0) begin
            check("rr_extra_grant", 1'b1, 1'b0);
          end else begin
            check("rr_owner", j, gq.pop_front());
          end
          check("rr_data", m_rd[j], s_rd);
          rem[j]--;
          prev_hs = 1'b1;
        end
      end
      cyc++;
    end
    check("rr_all_done", gq.size(), 0);
    check("rr_timeout_clear", o_timeout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
